// File: rtl/rf_writeback.sv
// rf_writeback: write-side controller for the register file.
//
// Merges single-cycle ALU results with variable-latency load responses onto
// the single register-file write port (WE3/AD3/WD3).
// - Load responses are buffered in a small FIFO.
// - A per-register scoreboard (busy) tracks outstanding loads, so decode can
//   stall on RAW hazards.
// - ALU results have priority over queued loads. A starvation counter forces
//   one drain cycle (alu_stall) after STARVE_LIMIT consecutive ALU wins.
//
// Optional feature, enabled by defining RF_WB_BYPASS_EN:
//   A load response accepted while the FIFO is empty and nothing else is
//   writing skips the FIFO and is written with latency 1 instead of 2.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_result      ALU result, single cycle
//   ld_issue/ld_issue_rd       load issued; reserves its destination in busy
//   ld_valid/ld_ready/ld_rd/ld_data  load response handshake
//   alu_stall                  forced-drain cycle; ALU must hold its result
//   busy                       scoreboard, one bit per register
//   WE3/AD3/WD3                registered register-file write port
module rf_writeback #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int LQ_DEPTH      = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_valid,
  input  logic [ADDRESS_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_result,
  input  logic                        ld_issue,
  input  logic [ADDRESS_WIDTH-1:0]    ld_issue_rd,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [ADDRESS_WIDTH-1:0]    ld_rd,
  input  logic [DATA_WIDTH-1:0]       ld_data,
  output logic                        alu_stall,
  output logic [2**ADDRESS_WIDTH-1:0] busy,
  output logic                        WE3,
  output logic [ADDRESS_WIDTH-1:0]    AD3,
  output logic [DATA_WIDTH-1:0]       WD3
);

  localparam int NREG  = 2**ADDRESS_WIDTH;
  localparam int PTR_W = $clog2(LQ_DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

`ifdef RF_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Load-response FIFO; the extra pointer bit separates full from empty.
  logic [ADDRESS_WIDTH-1:0] q_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0]    q_data [LQ_DEPTH];
  logic [PTR_W:0]           wr_ptr, rd_ptr;
  logic                     empty, full, accept, push, pop;

  logic                     alu_win, ld_write, wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_rd;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [CNT_W-1:0]         starve_cnt, starve_cnt_nxt;
  logic                     stall_nxt;
  logic [NREG-1:0]          busy_nxt;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign ld_ready = !full;
  assign accept   = ld_valid && ld_ready;

  // Write-port arbitration: forced drain, then ALU, then FIFO, then bypass.
  always_comb begin
    pop      = 1'b0;
    alu_win  = 1'b0;
    ld_write = 1'b0;
    wr_en    = 1'b0;
    wr_rd    = '0;
    wr_data  = '0;
    if (!empty && (alu_stall || !alu_valid)) begin
      pop      = 1'b1;
      ld_write = 1'b1;
      wr_en    = 1'b1;
      wr_rd    = q_rd[rd_ptr[PTR_W-1:0]];
      wr_data  = q_data[rd_ptr[PTR_W-1:0]];
    end else if (alu_valid) begin
      alu_win = 1'b1;
      wr_en   = 1'b1;
      wr_rd   = alu_rd;
      wr_data = alu_result;
    end else if (BYPASS && accept) begin
      // Empty FIFO, idle ALU: write the response straight through.
      ld_write = 1'b1;
      wr_en    = 1'b1;
      wr_rd    = ld_rd;
      wr_data  = ld_data;
    end
  end

  assign push = accept && !(ld_write && !pop);

  // Starvation counter counts ALU wins while loads wait; stall is registered.
  always_comb begin
    stall_nxt = alu_win && !empty && (starve_cnt == CNT_W'(STARVE_LIMIT - 1));
    if (pop || empty)
      starve_cnt_nxt = '0;
    else if (alu_win)
      starve_cnt_nxt = starve_cnt + 1'b1;
    else
      starve_cnt_nxt = starve_cnt;
  end

  // Scoreboard: a new issue wins over a same-register clear.
  always_comb begin
    busy_nxt = busy;
    if (ld_write)
      busy_nxt[wr_rd] = 1'b0;
    if (ld_issue)
      busy_nxt[ld_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Stage boundary: FIFO storage, not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr[PTR_W-1:0]]   <= ld_rd;
      q_data[wr_ptr[PTR_W-1:0]] <= ld_data;
    end
  end

  // Stage boundary: control state and registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      busy       <= '0;
      WE3        <= 1'b0;
      AD3        <= '0;
      WD3        <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      starve_cnt <= starve_cnt_nxt;
      alu_stall  <= stall_nxt;
      busy       <= busy_nxt;
      WE3        <= wr_en && (wr_rd != '0);
      AD3        <= wr_rd;
      WD3        <= wr_data;
    end
  end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_result;
  logic          ld_issue;
  logic [AW-1:0] ld_issue_rd;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_data;
  logic          alu_stall;
  logic [31:0]   busy;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  rf_writeback #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LQ_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .alu_stall(alu_stall), .busy(busy),
    .WE3(WE3), .AD3(AD3), .WD3(WD3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    int            due;
  } wr_t;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ld_t;

  wr_t   exp_q[$];
  ld_t   mq[$];
  int    m_starve;
  bit    m_stall;
  logic [31:0] m_busy;
  int    tests;
  int    fails;
  int    edges;
  wr_t   mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, req, edges);
    end
  endtask

  // Monitor: every cycle, compare the write port against the expected queue.
  always @(posedge clk) begin
    bit expw;
    edges = edges + 1;
    #1;
    expw = (exp_q.size() > 0) && (exp_q[0].due == edges);
    check("WE3", {63'd0, WE3}, {63'd0, expw});
    if (expw) begin
      mon_e = exp_q.pop_front();
      if (WE3 === 1'b1) begin
        check("AD3", {59'd0, AD3}, {59'd0, mon_e.rd});
        check("WD3", {32'd0, WD3}, {32'd0, mon_e.data});
      end
    end
  end

  // One cycle: check state outputs against the model, drive inputs, advance
  // the model (a queue of pending loads plus the arbitration rules).
  task automatic step(input bit r, input bit av, input logic [AW-1:0] ard,
                      input logic [DW-1:0] ares, input bit iss,
                      input logic [AW-1:0] isrd, input bit lv,
                      input logic [AW-1:0] lrd, input logic [DW-1:0] ldat);
    bit acc, was_empty, wr, popped, alu_won, byp, new_stall;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    ld_t l;
    @(negedge clk);
    check("ld_ready", {63'd0, ld_ready}, {63'd0, (mq.size() < DEPTH)});
    check("alu_stall", {63'd0, alu_stall}, {63'd0, m_stall});
    check("busy", {32'd0, busy}, {32'd0, m_busy});
    rst_n = r; alu_valid = av; alu_rd = ard; alu_result = ares;
    ld_issue = iss; ld_issue_rd = isrd; ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    if (!r) begin
      mq.delete();
      m_starve = 0;
      m_stall = 1'b0;
      m_busy = '0;
      return;
    end
    acc = lv && (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    wr = 0; popped = 0; alu_won = 0; byp = 0; rd = '0; data = '0;
    if (m_stall && !was_empty) begin
      l = mq.pop_front(); wr = 1; popped = 1; rd = l.rd; data = l.data;
    end else if (av) begin
      alu_won = 1; wr = 1; rd = ard; data = ares;
    end else if (!was_empty) begin
      l = mq.pop_front(); wr = 1; popped = 1; rd = l.rd; data = l.data;
    end else if (BYP && acc) begin
      byp = 1; wr = 1; rd = lrd; data = ldat;
    end
    if (popped || byp) m_busy[rd] = 1'b0;
    if (iss && isrd != 0) m_busy[isrd] = 1'b1;
    if (acc && !byp) mq.push_back('{rd: lrd, data: ldat});
    new_stall = alu_won && !was_empty && (m_starve == LIMIT - 1);
    if (popped || was_empty) m_starve = 0;
    else if (alu_won) m_starve = m_starve + 1;
    m_stall = new_stall;
    if (wr && rd != 0) exp_q.push_back('{rd: rd, data: data, due: edges + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int aprob;
    tests = 0; fails = 0; edges = 0;
    m_starve = 0; m_stall = 0; m_busy = '0;
    rst_n = 0; alu_valid = 0; alu_rd = 0; alu_result = 0;
    ld_issue = 0; ld_issue_rd = 0; ld_valid = 0; ld_rd = 0; ld_data = 0;

    // Reset held two cycles with an ALU result offered.
    step(0, 1, 5, 32'h1111_1111, 1, 3, 1, 4, 32'h2222_2222);
    step(0, 1, 5, 32'h1111_1111, 1, 3, 1, 4, 32'h2222_2222);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_AD3", {59'd0, AD3}, 64'd0);
    check("reset_WD3", {32'd0, WD3}, 64'd0);

    // ALU writes, including one to register 0.
    step(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    step(1, 1, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
    idle(2);

    // Load issue, then response while idle.
    step(1, 0, 0, 0, 1, 10, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 10, 32'h0000_1234);
    idle(3);

    // Backpressure: ALU busy while five loads are offered.
    for (int i = 0; i < 5; i++)
      step(1, 1, AW'(i + 20), DW'(32'hA000 + i), 1, AW'(i + 1), 1, AW'(i + 1), DW'(32'hB000 + i));
    step(1, 1, 26, 32'hA005, 0, 0, 1, 5, 32'hB004);
    idle(8);

    // Starvation: one queued load, ALU valid continuously.
    step(1, 1, 11, 32'hC000, 1, 12, 1, 12, 32'h5555_AAAA);
    for (int i = 1; i < 13; i++) step(1, 1, 11, DW'(32'hC000 + i), 0, 0, 0, 0, 0);
    idle(3);

    // Set/clear collision on register 7.
    step(1, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 1, 9, 32'h9999, 0, 0, 1, 7, 32'h7777);
    step(1, 0, 0, 0, 1, 7, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 7, 32'h7778);
    idle(3);

    // Randomized traffic in phases of differing ALU pressure.
    for (int p = 0; p < 24; p++) begin
      case (p % 3)
        0: aprob = 20;
        1: aprob = 55;
        default: aprob = 95;
      endcase
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 299) != 0,
             $urandom_range(0, 99) < aprob, AW'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 99) < 30, AW'($urandom_range(0, 7)),
             $urandom_range(0, 99) < 50, AW'($urandom_range(0, 7)), $urandom);
    end
    idle(30);

    @(posedge clk);
    #2;
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
